// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers wrap modulo DEPTH (power of two), push is refused when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 serial transmitter. Define UART_TX_PARITY_EN to insert an
// even parity bit between data bit 7 and the stop bit (11-bit frames).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    char,
    input  logic                          send,
    output logic                          busy,
    output logic                          out,
    output logic                          idle,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              out_q, out_d;
    logic              idle_q, idle_d;
    logic              overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic       bit_end;
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (char),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_push = send & ~fifo_full;
    assign bit_end   = (baud_q == BAUD_LAST);
    assign busy      = fifo_full;
    assign out       = out_q;
    assign idle      = idle_q;
    assign overflow  = overflow_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Popping in the last stop cycle chains frames with no idle gap.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout;
`endif
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered from the next state so it changes with the state.
        case (state_d)
            START:   out_d = LINE_START;
            DATA:    out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  out_d = parity_d;
`endif
            default: out_d = LINE_IDLE;
        endcase

        idle_d     = (state_d == IDLE) && fifo_empty;
        overflow_d = overflow_q | (send & fifo_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            out_q      <= LINE_IDLE;
            idle_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            out_q      <= out_d;
            idle_q     <= idle_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a line monitor decodes frames and
// compares them with bytes queued when the bench drives accepted sends.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FC = FRAME_BITS * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] tx_char;
    logic       send;
    logic       busy;
    logic       out;
    logic       idle;
    logic       overflow;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mon_frames = 0;

    logic [7:0] exp_q [$];
    int         starts [$];

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char       (tx_char),
        .send       (send),
        .busy       (busy),
        .out        (out),
        .idle       (idle),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Line monitor: samples one time unit after each rising edge.
    initial begin : rx_monitor
        logic [10:0] frm;
        logic [7:0]  eb;
        logic        ok;
        logic        stable;
        int          st;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && out === 1'b0) begin
                st  = cyc;
                ok  = 1'b1;
                frm = '0;
                for (int b = 0; b < FRAME_BITS && ok; b++) begin
                    stable = 1'b1;
                    for (int c = 0; c < CPB && ok; c++) begin
                        if (b != 0 || c != 0) begin
                            @(posedge clk);
                            #1;
                        end
                        if (rst) ok = 1'b0;
                        else if (c == 0) frm[b] = out;
                        else if (out !== frm[b]) stable = 1'b0;
                    end
                    if (ok) check_eq("bit_hold", {31'd0, stable}, 32'd1);
                end
                if (ok) begin
                    mon_frames++;
                    starts.push_back(st);
                    check_eq("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        eb = exp_q.pop_front();
                        check_eq("rx_frame", {21'd0, frm}, {21'd0, make_frame(eb)});
                    end
                end
            end
        end
    end

    task automatic send_cycle(input logic [7:0] b, input bit accept);
        tx_char = b;
        send    = 1'b1;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic send_one(input logic [7:0] b);
        send_cycle(b, 1'b1);
        send = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && idle !== 1'b1; i++) @(negedge clk);
        check_eq("idle_wait", {31'd0, idle}, 32'd1);
    endtask

    initial begin : stim
        int k;
        int f0;
        rst     = 1'b1;
        send    = 1'b0;
        tx_char = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_out", {31'd0, out}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_idle", {31'd0, idle}, 32'd1);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_count", {29'd0, fifo_count}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 'F': latency, frame length, idle return.
        starts.delete();
        send_one(8'h46);
        k = cyc;
        check_eq("f_out_e0", {31'd0, out}, 32'd1);
        check_eq("f_idle_e0", {31'd0, idle}, 32'd1);
        check_eq("f_count_e0", {29'd0, fifo_count}, 32'd1);
        @(negedge clk);
        check_eq("f_out_e1", {31'd0, out}, 32'd0);
        check_eq("f_idle_e1", {31'd0, idle}, 32'd0);
        wait_cyc(k + FC);
        check_eq("f_idle_last", {31'd0, idle}, 32'd0);
        @(negedge clk);
        check_eq("f_idle_end", {31'd0, idle}, 32'd1);
        check_eq("f_start_cyc", starts.size() > 0 ? starts[0] : -1, k + 1);
        check_eq("f_sb_drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // CR then LF: back-to-back frames, 2*FC cycles of activity.
        starts.delete();
        send_one(8'h0D);
        k = cyc;
        @(negedge clk);
        send_one(8'h0A);
        wait_cyc(k + 2 * FC);
        check_eq("crlf_idle_last", {31'd0, idle}, 32'd0);
        @(negedge clk);
        check_eq("crlf_idle_end", {31'd0, idle}, 32'd1);
        check_eq("crlf_nframes", starts.size(), 2);
        if (starts.size() == 2) check_eq("crlf_gap", starts[1] - starts[0], FC);
        check_eq("crlf_sb_drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Push in the same cycle as the final-stop-cycle pop at count 2.
        starts.delete();
        send_one(8'h31);
        k = cyc;
        @(negedge clk);
        send_one(8'h32);
        @(negedge clk);
        send_one(8'h33);
        wait_cyc(k + FC);
        check_eq("coin_pre_count", {29'd0, fifo_count}, 32'd2);
        send_one(8'h34);
        check_eq("coin_count", {29'd0, fifo_count}, 32'd2);
        check_eq("coin_nogap", {31'd0, out}, 32'd0);
        wait_idle(6 * FC);
        check_eq("coin_nframes", starts.size(), 4);
        check_eq("coin_sb_drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Six consecutive sends into a depth-4 FIFO while a frame is in flight.
        f0 = mon_frames;
        send_one(8'h50);
        k = cyc;
        wait_cyc(k + 1 + 2 * CPB);
        for (int i = 0; i < 6; i++) begin
            send_cycle(8'hA1 + 8'(i), i < 4);
            if (i == 3) begin
                check_eq("ovf_busy", {31'd0, busy}, 32'd1);
                check_eq("ovf_count4", {29'd0, fifo_count}, 32'd4);
                check_eq("ovf_early", {31'd0, overflow}, 32'd0);
            end
        end
        send = 1'b0;
        check_eq("ovf_flag", {31'd0, overflow}, 32'd1);
        check_eq("ovf_count", {29'd0, fifo_count}, 32'd4);
        wait_idle(8 * FC);
        check_eq("ovf_nframes", mon_frames - f0, 5);
        check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
        check_eq("ovf_sb_drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0x55 with 3 bytes queued.
        send_one(8'h55);
        k = cyc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            send_one(8'hC0 + 8'(i));
        end
        wait_cyc(k + 1 + 4 * CPB + 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_out", {31'd0, out}, 32'd1);
        check_eq("mrst_count", {29'd0, fifo_count}, 32'd0);
        check_eq("mrst_idle", {31'd0, idle}, 32'd1);
        check_eq("mrst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        f0 = mon_frames;
        repeat (3 * FC) @(negedge clk);
        check_eq("mrst_noframes", mon_frames - f0, 0);
        check_eq("mrst_out_hold", {31'd0, out}, 32'd1);

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x46 then 0x03, 44 cycles each.
        starts.delete();
        send_one(8'h46);
        @(negedge clk);
        send_one(8'h03);
        wait_idle(4 * FC);
        check_eq("par_nframes", starts.size(), 2);
        if (starts.size() == 2) check_eq("par_gap", starts[1] - starts[0], 44);
        check_eq("par_sb_drain", exp_q.size(), 0);
`endif

        repeat (5) @(negedge clk);
        check_eq("final_sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered 8-bit asynchronous serial transmitter that consumes the character stream produced by the FizzBuzz sequencer and drives the board's TX pin. Characters are accepted with a single-cycle `send` strobe into an internal FIFO, then serialised as 8N1 frames at a fixed baud rate. The FIFO lets the upstream sequencer emit a whole output line without waiting out each frame. `busy` is its only back-pressure signal.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per serial bit (100 MHz / 9600 baud); must be ≥ 2.
- `FIFO_DEPTH`, default 16: character slots; power of two, ≥ 2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `char`  in  8  character to transmit; sampled only when `send` is high.
- `send`  in  1  write strobe; one character per high cycle.
- `busy`  out  1  high when the FIFO holds `FIFO_DEPTH` entries; writes are not accepted.
- `out`  out  1  serial line; idle high; registered.
- `idle`  out  1  high when the FIFO is empty and no frame is in progress.
- `overflow`  out  1  sticky; set when `send` arrives while `busy` is high; cleared only by `rst`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Transmitter FSM states:
  - IDLE: `out` = 1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `out` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each for `CLKS_PER_BIT` cycles. A 3-bit counter runs 0..7; after bit 7 go to PARITY if configured, otherwise STOP.
  - PARITY (macro only): `out` = even parity bit for one bit time, then go to STOP.
  - STOP: `out` = 1 for `CLKS_PER_BIT` cycles. In its last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It resets to 0 on each state entry, and the bit ends when count == `CLKS_PER_BIT`-1.
- FIFO push and pop in the same cycle: both take effect and `fifo_count` is unchanged.
- A push is blocked only when the FIFO is full, even if a pop occurs in that cycle; the accepted behaviour is to drop the character and set `overflow`.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- `busy` = (`fifo_count` == `FIFO_DEPTH`); it is combinational from registered state.

## Timing
- Reset values: `out` = 1, `busy` = 0, `idle` = 1, `overflow` = 0, `fifo_count` = 0, FSM = IDLE, pointers = 0.
- Reset asserted mid-frame: `out` is 1 from the next edge, FIFO contents are discarded, and the frame is truncated.
- Latency: `send` sampled at edge E0 into an empty, idle block gives `out` = 0 from edge E1. `idle` falls at E1.
- Frame length: 10 × `CLKS_PER_BIT` cycles (11 × with parity).
- Back-to-back frames: the start bit of frame n+1 begins on the edge immediately after the last stop-bit cycle of frame n.
- `fifo_count` and `busy` update one edge after the causing `send` or pop.
- The upstream rule "send only when !busy and no send was issued in the previous cycle" can never overflow.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in, and an even parity bit (XOR of the 8 data bits) is inserted between bit 7 and stop. Frame = 11 bits.
- Undefined: the PARITY state and its logic are absent. Frame = 10 bits (8N1).

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Bit-count constant DATA_BITS = 8.
  - Line-level constants LINE_IDLE = 1 and LINE_START = 0.
- Sub-module `sync_fifo`: parameterised width/depth single-clock FIFO with push, pop, dout, count, full and empty. `uart_tx_buffered` contains the FSM, baud counter and shift register.

## Test plan
- `CLKS_PER_BIT` = 4, no macro, send 0x46 ("F") once:
  - `out` sequence, each value held 4 cycles: 0, 0,1,1,0,0,0,1,0, 1.
  - `out` falls exactly 1 cycle after the strobe; `idle` returns 1 after 40 cycles.
- Send "\r" (0x0D) then "\n" (0x0A) on consecutive allowed cycles: two frames with no gap, total 80 cycles of activity, decoded bytes 0x0D then 0x0A.
- `FIFO_DEPTH` = 4, 6 sends in 6 consecutive cycles:
  - `busy` high after the 4th accepted write.
  - 5th and 6th writes are dropped and `overflow` = 1.
  - Only 4 frames appear on `out`.
- Push coinciding with the STOP-final-cycle pop at `fifo_count` = 2: `fifo_count` stays 2 and bytes emerge in write order.
- Assert `rst` during DATA bit 3 of 0x55 with 3 bytes queued: `out` = 1 next edge, `fifo_count` = 0, `idle` = 1, `overflow` = 0, and no further frames appear.
- `UART_TX_PARITY_EN` defined, send 0x46 then 0x03: parity bits 1 then 0, each frame 44 cycles at `CLKS_PER_BIT` = 4.
